// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, PC-source selects
// and the bundle of per-stage control outputs.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_DIV_WAIT   = 3'd1,
      ST_MEM_WAIT   = 3'd2,
      ST_TRAP_FLUSH = 3'd3,
      ST_REDIRECT   = 3'd4
   } ctrl_state_e;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_TRAP   = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic       stall_if;
      logic       stall_id;
      logic       stall_ex;
      logic       bubble_ex;
      logic       flush_if_id;
      logic       flush_id_ex;
      logic       flush_ex_mem;
      logic [1:0] pc_sel;
      logic       trap_commit;
   } ctrl_out_t;

   function automatic ctrl_out_t ctrl_idle();
      ctrl_out_t c;
      c = '0;
      c.pc_sel = PC_SEL_SEQ;
      return c;
   endfunction

   function automatic ctrl_out_t ctrl_stall_all();
      ctrl_out_t c;
      c = ctrl_idle();
      c.stall_if = 1'b1;
      c.stall_id = 1'b1;
      c.stall_ex = 1'b1;
      return c;
   endfunction

   function automatic ctrl_out_t ctrl_flush_all();
      ctrl_out_t c;
      c = ctrl_idle();
      c.flush_if_id  = 1'b1;
      c.flush_id_ex  = 1'b1;
      c.flush_ex_mem = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sources from the pipeline and the stage controls returned to it.
// Divider handshake: ex_div_valid is held by the frozen EX stage until the
// cycle div_done is high; that cycle completes the transfer and no stall is raised.
interface pipe_hazard_ctrl_if;

   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic       ex_is_load;
   logic [4:0] ex_rd_addr;
   logic       ex_div_valid;
   logic       div_done;
   logic       mem_busy;
   logic       branch_taken;
   logic       trap_req;
   logic       irq_req;
   logic       irq_en;

   logic       stall_if;
   logic       stall_id;
   logic       stall_ex;
   logic       bubble_ex;
   logic       flush_if_id;
   logic       flush_id_ex;
   logic       flush_ex_mem;
   logic [1:0] pc_sel;
   logic       trap_commit;
   logic       trap_is_irq;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
      output ex_is_load, ex_rd_addr, ex_div_valid, div_done,
      output mem_busy, branch_taken, trap_req, irq_req, irq_en,
      input  stall_if, stall_id, stall_ex, bubble_ex,
      input  flush_if_id, flush_id_ex, flush_ex_mem,
      input  pc_sel, trap_commit, trap_is_irq
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
      input  ex_is_load, ex_rd_addr, ex_div_valid, div_done,
      input  mem_busy, branch_taken, trap_req, irq_req, irq_en,
      output stall_if, stall_id, stall_ex, bubble_ex,
      output flush_if_id, flush_id_ex, flush_ex_mem,
      output pc_sel, trap_commit, trap_is_irq
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: the instruction in ID reads the register a load in EX
// is about to write. x0 is never a real dependency.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs1_addr,
   input  logic [4:0] rs2_addr,
   input  logic       uses_rs1,
   input  logic       uses_rs2,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd_addr,
   output logic       load_use
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit  = uses_rs1 && (rs1_addr == ex_rd_addr);
      rs2_hit  = uses_rs2 && (rs2_addr == ex_rd_addr);
      load_use = ex_is_load && (ex_rd_addr != REG_ZERO) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: folds traps, interrupts, memory/divider waits,
// branches and load-use hazards into prioritised stall/bubble/flush controls.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_TIMEOUT  = 64,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   pipe_hazard_ctrl_if.slave ctl,
   output logic             err_div_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [2:0]       state
);

   localparam int               DIV_W      = $clog2(DIV_TIMEOUT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV_TIMEOUT - 1);
   localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);

   ctrl_state_e      state_q;
   ctrl_state_e      state_d;
   logic [DIV_W-1:0] div_cnt_q;
   logic [2:0]       flush_cnt_q;
   logic             trap_pending_q;
   logic             trap_is_irq_q;
   logic             err_q;
   logic [CNT_W-1:0] stall_cnt_q;

   logic             load_use;
   logic             take_trap;
   logic             take_irq;
   logic             div_stall_req;
   logic             div_timeout;
   ctrl_out_t        out_c;
   logic             trap_is_irq_c;

   hazard_detect u_hazard_detect (
      .rs1_addr   (ctl.id_rs1_addr),
      .rs2_addr   (ctl.id_rs2_addr),
      .uses_rs1   (ctl.id_uses_rs1),
      .uses_rs2   (ctl.id_uses_rs2),
      .ex_is_load (ctl.ex_is_load),
      .ex_rd_addr (ctl.ex_rd_addr),
      .load_use   (load_use)
   );

   // A trap raised while stalled is remembered and outranks everything in RUN.
   assign take_trap     = ctl.trap_req || trap_pending_q;
   assign take_irq      = ctl.irq_req && ctl.irq_en;
   assign div_stall_req = ctl.ex_div_valid && !ctl.div_done;
   assign div_timeout   = (state_q == ST_DIV_WAIT) && !ctl.div_done && (div_cnt_q == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (take_trap || take_irq) begin
               state_d = ST_TRAP_FLUSH;
            end else if (ctl.mem_busy) begin
               state_d = ST_MEM_WAIT;
            end else if (div_stall_req) begin
               state_d = ST_DIV_WAIT;
            end
         end
         ST_DIV_WAIT: begin
            if (ctl.div_done || div_timeout) begin
               state_d = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (!ctl.mem_busy) begin
               state_d = ST_RUN;
            end
         end
         ST_TRAP_FLUSH: begin
            if (flush_cnt_q <= 3'd1) begin
               state_d = ST_REDIRECT;
            end
         end
         ST_REDIRECT: state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase
   end

   // Controls are forced quiet while reset is held, even though they decode inputs.
   always_comb begin
      out_c         = ctrl_idle();
      trap_is_irq_c = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_RUN: begin
               if (take_trap || take_irq) begin
                  out_c = ctrl_flush_all();
               end else if (ctl.mem_busy || div_stall_req) begin
                  out_c = ctrl_stall_all();
               end else if (ctl.branch_taken) begin
                  out_c.flush_if_id = 1'b1;
                  out_c.flush_id_ex = 1'b1;
                  out_c.pc_sel      = PC_SEL_BRANCH;
               end else if (load_use) begin
                  out_c.stall_if  = 1'b1;
                  out_c.stall_id  = 1'b1;
                  out_c.bubble_ex = 1'b1;
               end
            end
            ST_DIV_WAIT: begin
               if (div_timeout) begin
                  out_c.flush_ex_mem = 1'b1;
               end else if (!ctl.div_done) begin
                  out_c = ctrl_stall_all();
               end
            end
            ST_MEM_WAIT: begin
               if (ctl.mem_busy) begin
                  out_c = ctrl_stall_all();
               end
            end
            ST_TRAP_FLUSH: out_c = ctrl_flush_all();
            ST_REDIRECT: begin
               out_c.pc_sel      = PC_SEL_TRAP;
               out_c.trap_commit = 1'b1;
               out_c.flush_if_id = 1'b1;
               trap_is_irq_c     = trap_is_irq_q;
            end
            default: out_c = ctrl_idle();
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q      <= '0;
         flush_cnt_q    <= '0;
         trap_pending_q <= 1'b0;
         trap_is_irq_q  <= 1'b0;
         err_q          <= 1'b0;
         stall_cnt_q    <= '0;
      end else begin
         if (state_q == ST_RUN) begin
            div_cnt_q <= '0;
         end else if (state_q == ST_DIV_WAIT) begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end

         if (state_q == ST_RUN) begin
            flush_cnt_q <= FLUSH_INIT;
         end else if (state_q == ST_TRAP_FLUSH) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
         end

         if (state_q == ST_REDIRECT) begin
            trap_pending_q <= 1'b0;
         end else if (ctl.trap_req && (state_q == ST_DIV_WAIT || state_q == ST_MEM_WAIT)) begin
            trap_pending_q <= 1'b1;
         end

         if (state_q == ST_RUN && (take_trap || take_irq)) begin
            trap_is_irq_q <= !take_trap;
         end

         if (div_timeout) begin
            err_q <= 1'b1;
         end

         if (out_c.stall_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   assign ctl.stall_if     = out_c.stall_if;
   assign ctl.stall_id     = out_c.stall_id;
   assign ctl.stall_ex     = out_c.stall_ex;
   assign ctl.bubble_ex    = out_c.bubble_ex;
   assign ctl.flush_if_id  = out_c.flush_if_id;
   assign ctl.flush_id_ex  = out_c.flush_id_ex;
   assign ctl.flush_ex_mem = out_c.flush_ex_mem;
   assign ctl.pc_sel       = out_c.pc_sel;
   assign ctl.trap_commit  = out_c.trap_commit;
   assign ctl.trap_is_irq  = trap_is_irq_c;

   assign err_div_timeout = err_q;
   assign stall_cycles    = stall_cnt_q;
   assign state           = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each driven cycle pushes its expected
// output vector; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

   localparam logic [2:0] S_ALL = 3'b111;
   localparam logic [2:0] S_LU  = 3'b110;
   localparam logic [2:0] NONE  = 3'b000;
   localparam logic [2:0] F_ALL = 3'b111;
   localparam logic [2:0] F_IF  = 3'b100;

   logic        clk = 1'b0;
   logic        reset;
   logic        err_div_timeout;
   logic [31:0] stall_cycles;
   logic [2:0]  state;

   logic [46:0] exp_q[$];
   string       tag_q[$];
   int          tests = 0;
   int          failed = 0;
   logic [31:0] exp_cnt = '0;
   logic        sticky_err = 1'b0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if hif ();

   pipe_hazard_ctrl #(
      .DIV_TIMEOUT  (64),
      .FLUSH_CYCLES (1),
      .CNT_W        (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .ctl             (hif),
      .err_div_timeout (err_div_timeout),
      .stall_cycles    (stall_cycles),
      .state           (state)
   );

   function automatic logic [14:0] mk_ctl(input logic [2:0] stl, input logic bub,
                                          input logic [2:0] fl, input logic [1:0] pcs,
                                          input logic tc, input logic ti, input logic [2:0] st);
      return {stl, bub, fl, pcs, tc, ti, sticky_err, st};
   endfunction

   task automatic idle();
      hif.id_rs1_addr  = '0;
      hif.id_rs2_addr  = '0;
      hif.id_uses_rs1  = 1'b0;
      hif.id_uses_rs2  = 1'b0;
      hif.ex_is_load   = 1'b0;
      hif.ex_rd_addr   = '0;
      hif.ex_div_valid = 1'b0;
      hif.div_done     = 1'b0;
      hif.mem_busy     = 1'b0;
      hif.branch_taken = 1'b0;
      hif.trap_req     = 1'b0;
      hif.irq_req      = 1'b0;
      hif.irq_en       = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   // stall_cycles seen this cycle counts only the earlier stalled cycles.
   task automatic push(input logic [14:0] c, input string t);
      exp_q.push_back({c, exp_cnt});
      tag_q.push_back(t);
      if (c[14]) exp_cnt = exp_cnt + 1;
   endtask

   always @(negedge clk) begin
      logic [46:0] act;
      logic [46:0] e;
      string       t;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         act = {hif.stall_if, hif.stall_id, hif.stall_ex, hif.bubble_ex,
                hif.flush_if_id, hif.flush_id_ex, hif.flush_ex_mem, hif.pc_sel,
                hif.trap_commit, hif.trap_is_irq, err_div_timeout, state, stall_cycles};
         tests++;
         if (act !== e) begin
            failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", t, act, e, $time);
         end
      end
   end

   initial begin
      idle();
      reset = 1'b1;
      cyc(); push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "reset");
      cyc(); reset = 1'b0;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "reset_release");

      // Load-use detection.
      cyc(); hif.ex_is_load = 1; hif.ex_rd_addr = 5'd5; hif.id_rs1_addr = 5'd5; hif.id_uses_rs1 = 1;
      push(mk_ctl(S_LU, 1, NONE, 2'b00, 0, 0, 3'd0), "load_use_rs1");
      cyc(); push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "load_use_one_cycle");
      cyc(); hif.ex_is_load = 1; hif.ex_rd_addr = 5'd0; hif.id_rs1_addr = 5'd0; hif.id_uses_rs1 = 1;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "load_use_x0");
      cyc(); hif.ex_is_load = 1; hif.ex_rd_addr = 5'd7; hif.id_rs1_addr = 5'd7; hif.id_rs2_addr = 5'd7;
      hif.id_uses_rs2 = 1;
      push(mk_ctl(S_LU, 1, NONE, 2'b00, 0, 0, 3'd0), "load_use_rs2");
      cyc(); hif.ex_is_load = 1; hif.ex_rd_addr = 5'd7; hif.id_rs2_addr = 5'd7;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "load_use_unused");
      cyc(); hif.ex_rd_addr = 5'd5; hif.id_rs1_addr = 5'd5; hif.id_uses_rs1 = 1;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "no_load");
      cyc(); hif.irq_req = 1; hif.irq_en = 0;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "irq_masked");

      // Branch alone, then divider done on the 10th wait cycle.
      cyc(); hif.branch_taken = 1;
      push(mk_ctl(NONE, 0, 3'b110, 2'b01, 0, 0, 3'd0), "branch");
      cyc(); hif.ex_div_valid = 1;
      push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd0), "div_start");
      for (int i = 1; i <= 10; i++) begin
         cyc(); hif.ex_div_valid = 1; hif.div_done = (i == 10);
         if (i < 10) push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd1), "div_wait");
         else        push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd1), "div_done");
      end
      cyc(); push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "div_back_run");
      cyc(); hif.ex_div_valid = 1; hif.div_done = 1;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "div_already_done");

      // Trap beats branch in the same cycle.
      cyc(); hif.branch_taken = 1; hif.trap_req = 1;
      push(mk_ctl(NONE, 0, F_ALL, 2'b00, 0, 0, 3'd0), "trap_vs_branch");
      cyc(); hif.branch_taken = 1; hif.trap_req = 1;
      push(mk_ctl(NONE, 0, F_ALL, 2'b00, 0, 0, 3'd3), "trap_flush");
      cyc(); push(mk_ctl(NONE, 0, F_IF, 2'b10, 1, 0, 3'd4), "trap_redirect");
      cyc(); push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "after_redirect");

      // Trap raised during a 4-cycle memory wait is deferred.
      cyc(); hif.mem_busy = 1; hif.ex_div_valid = 1;
      push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd0), "mem_start");
      for (int i = 1; i <= 3; i++) begin
         cyc(); hif.mem_busy = 1; hif.branch_taken = 1; hif.trap_req = (i == 1);
         push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd2), "mem_wait");
      end
      cyc(); hif.branch_taken = 1;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd2), "mem_release");
      cyc(); hif.branch_taken = 1;
      push(mk_ctl(NONE, 0, F_ALL, 2'b00, 0, 0, 3'd0), "pending_trap");
      cyc(); push(mk_ctl(NONE, 0, F_ALL, 2'b00, 0, 0, 3'd3), "pending_flush");
      cyc(); push(mk_ctl(NONE, 0, F_IF, 2'b10, 1, 0, 3'd4), "pending_redirect");
      cyc(); push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "pending_cleared");

      // Enabled interrupt outranks memory busy.
      cyc(); hif.irq_req = 1; hif.irq_en = 1; hif.mem_busy = 1;
      push(mk_ctl(NONE, 0, F_ALL, 2'b00, 0, 0, 3'd0), "irq_take");
      cyc(); hif.irq_req = 1; hif.irq_en = 1;
      push(mk_ctl(NONE, 0, F_ALL, 2'b00, 0, 0, 3'd3), "irq_flush");
      cyc(); push(mk_ctl(NONE, 0, F_IF, 2'b10, 1, 1, 3'd4), "irq_redirect");
      cyc(); push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "irq_done");

      // Divider never finishes.
      cyc(); hif.ex_div_valid = 1;
      push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd0), "to_start");
      for (int i = 1; i <= 64; i++) begin
         cyc(); hif.ex_div_valid = 1;
         if (i < 64) push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd1), "to_wait");
         else        push(mk_ctl(NONE, 0, 3'b001, 2'b00, 0, 0, 3'd1), "to_expire");
      end
      sticky_err = 1'b1;
      cyc(); push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "to_sticky");

      // Asynchronous reset in the middle of a divider wait.
      cyc(); hif.ex_div_valid = 1;
      push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd0), "rst_div_start");
      cyc(); hif.ex_div_valid = 1;
      push(mk_ctl(S_ALL, 0, NONE, 2'b00, 0, 0, 3'd1), "rst_div_wait");
      cyc(); hif.ex_div_valid = 1;
      #2;
      reset = 1'b1;
      sticky_err = 1'b0;
      exp_cnt = '0;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "async_reset");
      cyc(); reset = 1'b0;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "reset_release2");
      cyc(); hif.irq_req = 1; hif.irq_en = 0; hif.ex_div_valid = 1; hif.div_done = 1;
      push(mk_ctl(NONE, 0, NONE, 2'b00, 0, 0, 3'd0), "irq_masked2");

      repeat (3) @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
